// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester/bank bus shared by the write-port arbiter
interface regfile_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int n    = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*n-1:0]  req_data;
  logic [NREQ-1:0]    ack;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [n-1:0]       wr_data;
  logic [NREG-1:0]    wr_sel;
  logic               busy;

  // Requester side drives the requests and watches the issued write.
  modport master (
    output req, req_addr, req_data,
    input  ack, wr_en, wr_addr, wr_data, wr_sel, busy
  );

  // Arbiter side owns the write port and the acks.
  modport slave (
    input  req, req_addr, req_data,
    output ack, wr_en, wr_addr, wr_data, wr_sel, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register bank write port
module regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int n    = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] elig;
  logic [PW-1:0]   cand;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   ptr_next;
  logic [AW-1:0]   win_addr;
  logic [n-1:0]    win_data;
  logic [NREG-1:0] win_sel;

  // Pick the first eligible requester starting at ptr; the current ack holder
  // is masked because its req is still high during its ack cycle.
  always_comb begin
    elig     = bus.req & ~bus.ack;
    cand     = '0;
    found    = 1'b0;
    win      = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        win_addr = bus.req_addr[i*AW +: AW];
        win_data = bus.req_data[i*n +: n];
      end
    end
    win_sel  = (win_addr != '0) ? (NREG'(1) << win_addr) : '0;
    ptr_next = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // Register the grant and the write; address/data hold while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      bus.ack     <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.wr_sel  <= '0;
      bus.busy    <= 1'b0;
    end else if (found) begin
      ptr         <= ptr_next;
      bus.ack     <= NREQ'(1) << win;
      bus.wr_en   <= 1'b1;
      bus.wr_addr <= win_addr;
      bus.wr_data <= win_data;
      bus.wr_sel  <= win_sel;
      bus.busy    <= 1'b1;
    end else begin
      bus.ack     <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_sel  <= '0;
      bus.busy    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct {
    logic                rstn;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*N-1:0]   data;
    logic [NREQ-1:0]     e_ack;
    logic                e_en;
    logic [AW-1:0]       e_addr;
    logic [N-1:0]        e_data;
  } vec_t;

  localparam logic [19:0]  ADDR_A = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [127:0] DATA_A = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [19:0]  ADDR_1 = {15'd0, 5'd5};
  localparam logic [127:0] DATA_1 = {96'd0, 32'hDEADBEEF};
  localparam logic [127:0] DATA_Z = {64'd0, 32'hCAFEF00D, 32'd0};
  localparam logic [19:0]  ADDR_7 = {5'd7, 15'd0};
  localparam logic [127:0] DATA_7 = {32'h77777777, 96'd0};

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt[$];
  logic [N-1:0] bank [NREG] = '{default: '0};

  regfile_write_arbiter_if #(.NREQ(NREQ), .n(N), .NREG(NREG)) bus ();

  regfile_write_arbiter #(.NREQ(NREQ), .n(N), .NREG(NREG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++)
      if (bus.wr_sel[i]) bank[i] <= bus.wr_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREG-1:0] sel_of(input logic en, input logic [AW-1:0] a);
    logic [NREG-1:0] one;
    one = 1;
    return (en && a != 0) ? (one << a) : '0;
  endfunction

  task automatic add(input logic rstn, input logic [3:0] req, input logic [19:0] addr,
                     input logic [127:0] data, input logic [3:0] e_ack, input logic e_en,
                     input logic [4:0] e_addr, input logic [31:0] e_data);
    vec_t v;
    v = '{rstn, req, addr, data, e_ack, e_en, e_addr, e_data};
    vt.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] e_ack, input logic e_en,
                               input logic [4:0] e_addr, input logic [31:0] e_data);
    chk({tag, " ack"},     64'(bus.ack),     64'(e_ack));
    chk({tag, " wr_en"},   64'(bus.wr_en),   64'(e_en));
    chk({tag, " wr_addr"}, 64'(bus.wr_addr), 64'(e_addr));
    chk({tag, " wr_data"}, 64'(bus.wr_data), 64'(e_data));
    chk({tag, " wr_sel"},  64'(bus.wr_sel),  64'(sel_of(e_en, e_addr)));
    chk({tag, " busy"},    64'(bus.busy),    64'(e_en));
  endtask

  initial begin
    reset        = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;

    // reset for three cycles, then a single request
    add(0, 4'b0000, 20'd0,  128'd0, 4'b0000, 0, 5'd0, 32'h0);
    add(0, 4'b0000, 20'd0,  128'd0, 4'b0000, 0, 5'd0, 32'h0);
    add(0, 4'b0000, 20'd0,  128'd0, 4'b0000, 0, 5'd0, 32'h0);
    add(1, 4'b0001, ADDR_1, DATA_1, 4'b0001, 1, 5'd5, 32'hDEADBEEF);
    add(1, 4'b0001, ADDR_1, DATA_1, 4'b0000, 0, 5'd5, 32'hDEADBEEF);
    add(1, 4'b0000, ADDR_1, DATA_1, 4'b0000, 0, 5'd5, 32'hDEADBEEF);
    // reset again, then all four requesters held
    add(0, 4'b0000, ADDR_A, DATA_A, 4'b0000, 0, 5'd0, 32'h0);
    add(1, 4'b1111, ADDR_A, DATA_A, 4'b0001, 1, 5'd1, 32'h11111111);
    add(1, 4'b1111, ADDR_A, DATA_A, 4'b0010, 1, 5'd2, 32'h22222222);
    add(1, 4'b1111, ADDR_A, DATA_A, 4'b0100, 1, 5'd3, 32'h33333333);
    add(1, 4'b1111, ADDR_A, DATA_A, 4'b1000, 1, 5'd4, 32'h44444444);
    add(1, 4'b1111, ADDR_A, DATA_A, 4'b0001, 1, 5'd1, 32'h11111111);
    // pointer wrap: requester 2 alone, then 0 and 2 together
    add(1, 4'b0100, ADDR_A, DATA_A, 4'b0100, 1, 5'd3, 32'h33333333);
    add(1, 4'b0101, ADDR_A, DATA_A, 4'b0001, 1, 5'd1, 32'h11111111);
    add(1, 4'b0101, ADDR_A, DATA_A, 4'b0100, 1, 5'd3, 32'h33333333);
    add(1, 4'b0000, ADDR_A, DATA_A, 4'b0000, 0, 5'd3, 32'h33333333);
    // write to hardwired-zero address
    add(1, 4'b0010, 20'd0,  DATA_Z, 4'b0010, 1, 5'd0, 32'hCAFEF00D);
    add(1, 4'b0000, 20'd0,  DATA_Z, 4'b0000, 0, 5'd0, 32'hCAFEF00D);
    // one requester holding req for six cycles
    for (int i = 0; i < 3; i++) begin
      add(1, 4'b1000, ADDR_7, DATA_7, 4'b1000, 1, 5'd7, 32'h77777777);
      add(1, 4'b1000, ADDR_7, DATA_7, 4'b0000, 0, 5'd7, 32'h77777777);
    end
    add(1, 4'b0000, ADDR_7, DATA_7, 4'b0000, 0, 5'd7, 32'h77777777);

    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk);
      reset        = vt[k].rstn;
      bus.req      = vt[k].req;
      bus.req_addr = vt[k].addr;
      bus.req_data = vt[k].data;
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", k), vt[k].e_ack, vt[k].e_en, vt[k].e_addr, vt[k].e_data);
    end

    // reset asserted in the middle of an ack cycle
    @(negedge clk);
    bus.req      = 4'b0100;
    bus.req_addr = {5'd0, 5'd9, 10'd0};
    bus.req_data = {32'd0, 32'hABCD1234, 64'd0};
    @(posedge clk);
    #1;
    check_outputs("mid pre", 4'b0100, 1'b1, 5'd9, 32'hABCD1234);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("mid rst", 4'b0000, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk("mid no capture", 64'(bank[9]), 64'h0);
    @(negedge clk);
    reset        = 1'b1;
    bus.req      = 4'b1010;
    bus.req_addr = {5'd8, 5'd0, 5'd6, 5'd0};
    bus.req_data = {32'h88888888, 32'd0, 32'h66666666, 32'd0};
    @(posedge clk);
    #1;
    check_outputs("post rst a", 4'b0010, 1'b1, 5'd6, 32'h66666666);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_outputs("post rst b", 4'b1000, 1'b1, 5'd8, 32'h88888888);
    @(negedge clk);
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    check_outputs("post rst idle", 4'b0000, 1'b0, 5'd8, 32'h88888888);

    chk("bank[5]", 64'(bank[5]), 64'hDEADBEEF);
    chk("bank[7]", 64'(bank[7]), 64'h77777777);
    chk("bank[0]", 64'(bank[0]), 64'h0);
    chk("bank[6]", 64'(bank[6]), 64'h66666666);
    chk("bank[8]", 64'(bank[8]), 64'h88888888);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
